// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time statistics block.
// Holds the display-mode and conversion-FSM enums plus time-width constants.
// No logic; imported by reaction_stats and stats_window.
package reaction_pkg;

  localparam int TIME_W           = 14;
  localparam int MAX_TIME_DEFAULT = 9999;

  typedef enum logic [2:0] {
    MODE_LAST  = 3'd0,
    MODE_BEST  = 3'd1,
    MODE_AVG   = 3'd2,
    MODE_COUNT = 3'd3,
    MODE_WORST = 3'd4
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_BUSY   = 2'd2
  } state_t;

  // Saturate a raw time at the timeout value.
  function automatic logic [TIME_W-1:0] clamp_time(input logic [TIME_W-1:0] t,
                                                   input logic [TIME_W-1:0] max_t);
    return (t >= max_t) ? max_t : t;
  endfunction

endpackage

// File: rtl/stats_window.sv
// Moving-average window: circular buffer of 2^DEPTH_LOG2 entries with running sum.
// Latency: sum/full reflect a push or clear on the following cycle.
// No backpressure: a push is always accepted; clear has priority over push.
module stats_window
  import reaction_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic                         clear,
  input  logic [TIME_W-1:0]            din,
  output logic [TIME_W+DEPTH_LOG2-1:0] sum,
  output logic                         full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SUM_W = TIME_W + DEPTH_LOG2;

  logic [TIME_W-1:0]     entry [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2:0]   fill;

  assign full = (fill == (DEPTH_LOG2 + 1)'(DEPTH));

  // Replace the oldest entry and adjust the running sum by the difference.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
      wptr <= '0;
      fill <= '0;
      sum  <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
      wptr <= '0;
      fill <= '0;
      sum  <= '0;
    end else if (push) begin
      sum         <= sum + SUM_W'(din) - SUM_W'(entry[wptr]);
      entry[wptr] <= din;
      wptr        <= wptr + DEPTH_LOG2'(1);
      if (!full) fill <= fill + (DEPTH_LOG2 + 1)'(1);
    end
  end

endmodule

// File: rtl/reaction_stats.sv
// Reaction statistics (last/best/avg/count, worst with STATS_WORST_EN) feeding a BCD converter.
// Latency: result to bcd_start is 2 cycles with the converter idle; events coalesce while busy.
// Backpressure: bcd_start only issues when bcd_ready=1; pending updates wait for the converter.
module reaction_stats
  import reaction_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2,
  parameter int MAX_TIME   = MAX_TIME_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              result_valid,
  input  logic [TIME_W-1:0] result_time,
  input  logic              clear_stats,
  input  logic              mode_next,
  input  logic              bcd_ready,
  output logic              bcd_start,
  output logic [TIME_W-1:0] bin_out,
  output logic [2:0]        mode,
  output logic              avg_valid
);

  localparam int SUM_W = TIME_W + DEPTH_LOG2;
  localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_TIME);

  logic [TIME_W-1:0] t_clamped;
  logic              timeout;
  logic [TIME_W-1:0] last_t, best_t, count_t, sel;
  logic [SUM_W-1:0]  win_sum;
  logic              win_full;
  logic              any_event, launch, pending;
  state_t            state;

  assign t_clamped = clamp_time(result_time, MAX_T);
  assign timeout   = (t_clamped == MAX_T);
  assign any_event = result_valid | mode_next | clear_stats;
  assign avg_valid = win_full;

`ifdef STATS_WORST_EN
  logic [2:0]        mode_idx;
  logic [TIME_W-1:0] worst_t;
  assign mode = mode_idx;

  // Worst tracks the slowest non-timeout result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                      worst_t <= '0;
    else if (clear_stats)                              worst_t <= '0;
    else if (result_valid && !timeout && t_clamped > worst_t) worst_t <= t_clamped;
  end

  // Mode cycles LAST..WORST and wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       mode_idx <= '0;
    else if (mode_next) mode_idx <= (mode_idx == 3'(MODE_WORST)) ? 3'd0 : mode_idx + 3'd1;
  end
`else
  logic [1:0] mode_idx;
  assign mode = {1'b0, mode_idx};

  // Mode cycles LAST..COUNT; the 2-bit counter wraps 3->0 by itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       mode_idx <= '0;
    else if (mode_next) mode_idx <= mode_idx + 2'd1;
  end
`endif

  stats_window #(.DEPTH_LOG2(DEPTH_LOG2)) u_window (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (result_valid && !timeout && !clear_stats),
    .clear   (clear_stats),
    .din     (t_clamped),
    .sum     (win_sum),
    .full    (win_full)
  );

  // Last/best/count registers; clear discards a coincident result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_t  <= '0;
      best_t  <= MAX_T;
      count_t <= '0;
    end else if (clear_stats) begin
      last_t  <= '0;
      best_t  <= MAX_T;
      count_t <= '0;
    end else if (result_valid) begin
      last_t <= t_clamped;
      if (count_t < MAX_T) count_t <= count_t + TIME_W'(1);
      if (!timeout && t_clamped < best_t) best_t <= t_clamped;
    end
  end

  // Pick the figure for the current mode; AVG reads 0 until the window fills.
  always_comb begin
    sel = '0;
    case (mode_t'(mode))
      MODE_LAST:  sel = last_t;
      MODE_BEST:  sel = best_t;
      MODE_AVG:   sel = win_full ? win_sum[SUM_W-1:DEPTH_LOG2] : '0;
      MODE_COUNT: sel = count_t;
`ifdef STATS_WORST_EN
      MODE_WORST: sel = worst_t;
`endif
      default:    sel = '0;
    endcase
  end

  assign launch = (state == S_IDLE) && pending && bcd_ready;

  // Conversion handshake; LAUNCH masks the converter's one-cycle ready drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      bcd_start <= 1'b0;
      bin_out   <= '0;
      pending   <= 1'b1;
    end else begin
      bcd_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (launch) begin
            bin_out   <= sel;
            bcd_start <= 1'b1;
            state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: state <= S_BUSY;
        S_BUSY:   if (bcd_ready) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
      // A new event wins over the launch clearing pending, so nothing is lost.
      if (any_event)   pending <= 1'b1;
      else if (launch) pending <= 1'b0;
    end
  end

endmodule

// File: doc/reaction_stats.md
Name: reaction_stats

Overview:
- Downstream of the reaction timer FSM and upstream of the binary-to-BCD converter.
- Captures each completed reaction time and maintains last, best and moving-average statistics, plus a trial count.
- Selects one statistic per display mode and hands it to the BCD converter through a start/ready handshake, so the seven-segment display shows the chosen figure.

Parameters:
- DEPTH_LOG2, 2, log2 of the moving-average window (window = 4 trials).
- MAX_TIME, 9999, saturation value in ms; results at or above it count as timeouts.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- result_valid  in  1  one-cycle pulse; result_time is valid this cycle
- result_time  in  14  reaction time, ms
- clear_stats  in  1  one-cycle pulse (debounced); wipes all statistics
- mode_next  in  1  one-cycle pulse (debounced); advances display mode
- bcd_ready  in  1  converter idle
- bcd_start  out  1  one-cycle conversion request
- bin_out  out  14  value to convert; stable from bcd_start until the next bcd_start
- mode  out  3  current mode: 0 LAST, 1 BEST, 2 AVG, 3 COUNT (4 WORST when the optional feature is enabled)
- avg_valid  out  1  window full, so AVG is meaningful

Behaviour:
- Reset values: bcd_start=0, bin_out=0, mode=0, avg_valid=0. Internally last=0, best=MAX_TIME, sum=0, count=0, window entries=0, write pointer=0, fill=0, FSM in S_IDLE, pending=1 (forces an initial display of 0).
- Clamp: t = min(result_time, MAX_TIME). Every result_valid sets last=t and count=count+1, saturating at 9999.
- Timeouts: if t==MAX_TIME the result is a timeout. It updates last and count only; best and the window are unchanged.
- Best: best=min(best,t). A best of MAX_TIME displays as 9999.
- Window: circular buffer of 2^DEPTH_LOG2 entries, 14 bits each.
  - Push: sum <= sum + t - entry[wptr]; entry[wptr] <= t; wptr wraps modulo the depth.
  - sum is 14+DEPTH_LOG2 bits wide and never overflows.
  - fill saturates at the depth; avg_valid = (fill == depth).
- AVG = sum >> DEPTH_LOG2 (truncating). It displays 0 while avg_valid=0.
- Statistics update registers on the cycle after result_valid. bin_out reflects them no earlier than the next bcd_start.
- mode_next: mode wraps 3->0 (4->0 with the feature). Any mode change sets pending.
- clear_stats: restores all reset values except mode, and sets pending.
- Simultaneous events:
  - clear_stats together with result_valid: clear wins and the result is discarded.
  - mode_next together with result_valid: both take effect.
- Conversion FSM:
  - S_IDLE: if pending and bcd_ready, latch bin_out=selected value, bcd_start=1, clear pending, go to S_LAUNCH.
  - S_LAUNCH: one cycle with bcd_ready ignored, to cover the converter's ready drop latency; go to S_BUSY.
  - S_BUSY: wait for bcd_ready=1, then go to S_IDLE.
  - Any result_valid, mode change or clear sets pending in any state. Pending events coalesce into a single conversion that uses the values current at launch.
  - bcd_start is never asserted while bcd_ready=0.
  - Latency: new result to bcd_start is 2 cycles when the converter is idle.
- Reset mid-conversion: FSM returns to S_IDLE with pending=1. The converter is reset by the same reset_n.

Optional Feature:
- Macro STATS_WORST_EN.
- Defined: adds a worst register (reset 0, worst=max(worst,t) over non-timeout results) and mode 4 WORST; mode wraps 4->0.
- Undefined: no worst register and mode wraps 3->0. The mode port stays 3 bits with bit 2 tied to 0.

Decomposition:
- Shared package reaction_pkg holds:
  - the mode enum (MODE_LAST, MODE_BEST, MODE_AVG, MODE_COUNT, MODE_WORST);
  - the FSM state enum (S_IDLE, S_LAUNCH, S_BUSY);
  - MAX_TIME_DEFAULT=9999;
  - TIME_W=14.
- One sub-module, stats_window: circular buffer plus running sum and fill counter, exposing push, clear, sum and full.

Test Plan:
- Reset, then bcd_ready=1 -> one bcd_start with bin_out=0, mode=0.
- Results 250, 180, 300, 200 -> LAST=200, BEST=180, AVG=232, COUNT=4, avg_valid=1 after the 4th; a fifth result of 400 -> AVG=270.
- Results 9999 and 12000 -> last=9999, count increments, best and window unchanged, avg_valid stays 0.
- Hold bcd_ready=0 while 3 results and 2 mode_next pulses arrive -> exactly one bcd_start after ready returns, with the value for mode 2.
- clear_stats in the same cycle as result_valid(150) -> count=0, best displays 9999, bin_out=0 in LAST.
- With STATS_WORST_EN, results 120 and 450 -> mode_next pulses step through 0..4 and back to 0; in WORST, bin_out=450.
